// File: rtl/modulo_varredura_display_if.sv
// Display-side bundle for the 4-digit scan controller: scan reference and digit data in,
// anode/segment/decimal-point drive out.
interface modulo_varredura_display_if;
  logic        clk_div;
  logic [15:0] dado;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output clk_div, dado, dp_in, input an, seg, dp);
  modport slave  (input clk_div, dado, dp_in, output an, seg, dp);
endinterface

// File: rtl/modulo_varredura_display.sv
// 4-digit common-anode 7-segment scan controller with inter-digit blanking.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module modulo_varredura_display #(
  parameter int BLANK_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                             clk,
  input  logic                             clr,
  modulo_varredura_display_if.slave        disp
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [7:0] BCNT_LOAD = 8'(BLANK_CYCLES - 1);

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   r_tick;
  logic [1:0]             r_idx, w_idx_next;
  logic [19:0]            r_frame, w_frame_next;
  logic [7:0]             r_bcnt, w_bcnt_next;
  logic [3:0]             r_an, w_an_next;
  logic [6:0]             r_seg, w_seg_next;
  logic                   r_dp, w_dp_next;
  logic [3:0]             w_digits [4];

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  // Rising edge of the synchronised reference becomes a one-cycle registered tick.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], disp.clk_div};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_tick      <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_frame <= '0;
      r_bcnt  <= '0;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_frame <= w_frame_next;
      r_bcnt  <= w_bcnt_next;
      r_an    <= w_an_next;
      r_seg   <= w_seg_next;
      r_dp    <= w_dp_next;
    end
  end

  // Ticks seen while blanking fall through the BLANK arm untouched, i.e. are dropped.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_frame_next = r_frame;
    w_bcnt_next  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (r_tick) begin
          w_frame_next = {disp.dado, disp.dp_in};
          w_idx_next   = 2'd0;
          w_state_next = SHOW;
        end
      end
      SHOW: begin
        if (r_tick) begin
          w_bcnt_next  = BCNT_LOAD;
          w_state_next = BLANK;
        end
      end
      BLANK: begin
        if (r_bcnt == 8'd0) begin
          w_idx_next   = r_idx + 2'd1;
          w_state_next = SHOW;
          if (r_idx == 2'd3) begin
            w_frame_next = {disp.dado, disp.dp_in};
          end
        end else begin
          w_bcnt_next = r_bcnt - 8'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign w_digits[gi] = w_frame_next[4 + 4*gi +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed only if it and everything above it is zero with no dp request.
  logic [3:0] w_lz_blank;
  assign w_lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign w_lz_blank[gi] = (w_frame_next[19:4+4*gi] == '0) && (w_frame_next[3:gi] == '0);
  end
`endif

  // Outputs are computed from the upcoming state so they register alongside it.
  always_comb begin
    w_an_next  = 4'hF;
    w_seg_next = 7'h7F;
    w_dp_next  = 1'b1;
    if (w_state_next == SHOW) begin
      w_an_next  = ~(4'b0001 << w_idx_next);
      w_seg_next = f_decode(w_digits[w_idx_next]);
      w_dp_next  = ~w_frame_next[w_idx_next];
`ifdef LEADING_ZERO_BLANK_EN
      if (w_lz_blank[w_idx_next]) begin
        w_seg_next = 7'h7F;
      end
`endif
    end
  end

  assign disp.an  = r_an;
  assign disp.seg = r_seg;
  assign disp.dp  = r_dp;

endmodule
